// File: rtl/svc_rv_regfile.sv
// svc_rv_regfile: RISC-V integer register file, 32 x XLEN, two read ports and
// one write port. The storage is either a flop array with combinational read
// (MEM_TYPE=0) or a BRAM-style array with a registered, read-first read
// (MEM_TYPE=1). With INIT_ZERO=1, a sweep after reset writes 0 to x1..x31
// before WB writes are accepted.
//
// Ports:
//   clk           clock
//   rst_n         synchronous active-low reset (does not clear the array)
//   read_en       read-port advance, MEM_TYPE=1 only (0 = hold outputs)
//   rs1_id/rs2_id read addresses
//   rs1_data_id   read data port 1 (0 for x0 and while init_busy)
//   rs2_data_id   read data port 2
//   rd_wb         write address
//   reg_write_wb  write enable
//   rd_data_wb    write data
//   init_busy     zeroing sweep in progress; fetch must hold while high
module svc_rv_regfile #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MEM_TYPE  = 0,
  parameter int unsigned INIT_ZERO = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            read_en,
  input  logic [4:0]      rs1_id,
  input  logic [4:0]      rs2_id,
  output logic [XLEN-1:0] rs1_data_id,
  output logic [XLEN-1:0] rs2_data_id,
  input  logic [4:0]      rd_wb,
  input  logic            reg_write_wb,
  input  logic [XLEN-1:0] rd_data_wb,
  output logic            init_busy
);

  localparam int unsigned NREGS = 32;

  logic [XLEN-1:0] mem_q [NREGS];

  logic            init_we;
  logic [4:0]      init_idx;
  logic            wb_we;
  logic            mem_we;
  logic [4:0]      mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  // WB writes are dropped (not queued) during reset and during the sweep.
  assign wb_we = reg_write_wb && (rd_wb != 5'd0) && !init_busy && rst_n;

  // Single physical write port, shared by the sweep and WB (never both).
  assign mem_we    = wb_we || init_we;
  assign mem_waddr = init_we ? init_idx : rd_wb;
  assign mem_wdata = init_we ? '0 : rd_data_wb;

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  generate
    if (INIT_ZERO != 0) begin : g_init
      localparam logic [0:0] ST_RUN  = 1'b0;
      localparam logic [0:0] ST_INIT = 1'b1;

      logic [0:0] state_q, state_d;
      logic [4:0] idx_q, idx_d;

      // Sweep state and index registers.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_q <= ST_INIT;
          idx_q   <= 5'd1;
        end else begin
          state_q <= state_d;
          idx_q   <= idx_d;
        end
      end

      // Next state: step idx through 1..31, leave INIT after writing x31.
      always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == ST_INIT) begin
          idx_d = idx_q + 5'd1;
          if (idx_q == 5'd31) begin
            state_d = ST_RUN;
          end
        end
      end

      assign init_busy = (state_q == ST_INIT);
      assign init_we   = init_busy && rst_n;
      assign init_idx  = idx_q;
    end else begin : g_no_init
      assign init_busy = 1'b0;
      assign init_we   = 1'b0;
      assign init_idx  = 5'd0;
    end
  endgenerate

  generate
    if (MEM_TYPE == 0) begin : g_async_rd
      logic unused_read_en;
      assign unused_read_en = read_en;

      // Combinational read, no bypass: a same-cycle write shows up next cycle.
      assign rs1_data_id = (init_busy || (rs1_id == 5'd0)) ? '0 : mem_q[rs1_id];
      assign rs2_data_id = (init_busy || (rs2_id == 5'd0)) ? '0 : mem_q[rs2_id];
    end else begin : g_sync_rd
      logic [XLEN-1:0] rd1_q, rd1_d;
      logic [XLEN-1:0] rd2_q, rd2_d;

      // Read-first: the array value sampled here predates any same-edge write.
      always_comb begin
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        if (init_busy) begin
          rd1_d = '0;
          rd2_d = '0;
        end else if (read_en) begin
          rd1_d = (rs1_id == 5'd0) ? '0 : mem_q[rs1_id];
          rd2_d = (rs2_id == 5'd0) ? '0 : mem_q[rs2_id];
        end
      end

      // Read output registers.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd1_q <= '0;
          rd2_q <= '0;
        end else begin
          rd1_q <= rd1_d;
          rd2_q <= rd2_d;
        end
      end

      assign rs1_data_id = rd1_q;
      assign rs2_data_id = rd2_q;
    end
  endgenerate

endmodule

// File: tb/tb_svc_rv_regfile.sv
// Testbench for svc_rv_regfile: one flop-array instance and one BRAM-style
// instance share all inputs; both are compared each cycle against a
// behavioural register-file model, plus directed vector and sequence checks.
module tb_svc_rv_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_en;
  logic [4:0]  rs1_id, rs2_id, rd_wb;
  logic        reg_write_wb;
  logic [31:0] rd_data_wb;
  logic [31:0] a_rs1, a_rs2, b_rs1, b_rs2;
  logic        a_busy, b_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  svc_rv_regfile #(.XLEN(32), .MEM_TYPE(0), .INIT_ZERO(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .read_en(read_en),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_data_id(a_rs1), .rs2_data_id(a_rs2),
    .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .rd_data_wb(rd_data_wb),
    .init_busy(a_busy)
  );

  svc_rv_regfile #(.XLEN(32), .MEM_TYPE(1), .INIT_ZERO(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .read_en(read_en),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_data_id(b_rs1), .rs2_data_id(b_rs2),
    .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .rd_data_wb(rd_data_wb),
    .init_busy(b_busy)
  );

  // Reference model: register contents, remaining sweep cycles, and the
  // registered read values of the BRAM-style instance.
  logic [31:0] ref_mem [32];
  int          sweep_left = 31;
  logic [31:0] ref_q1 = 32'd0;
  logic [31:0] ref_q2 = 32'd0;

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (sweep_left > 0 || a == 5'd0) return 32'd0;
    return ref_mem[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Set inputs for one cycle and compare both instances with the model.
  task automatic apply(input logic rn, input logic we, input logic [4:0] rd,
                       input logic [31:0] wd, input logic [4:0] a1,
                       input logic [4:0] a2, input logic ren);
    rst_n = rn; reg_write_wb = we; rd_wb = rd; rd_data_wb = wd;
    rs1_id = a1; rs2_id = a2; read_en = ren;
    #1;
    chk("busy_a", 32'(a_busy), 32'(sweep_left > 0));
    chk("busy_b", 32'(b_busy), 32'(sweep_left > 0));
    chk("a_rs1", a_rs1, ref_read(a1));
    chk("a_rs2", a_rs2, ref_read(a2));
    chk("b_rs1", b_rs1, ref_q1);
    chk("b_rs2", b_rs2, ref_q2);
  endtask

  // Advance one clock edge; the model consumes the inputs held across it.
  task automatic adv();
    bit busy;
    @(posedge clk);
    busy = (sweep_left > 0);
    if (!rst_n) begin
      sweep_left = 31;
      ref_q1 = 32'd0;
      ref_q2 = 32'd0;
    end else begin
      if (busy) begin
        ref_q1 = 32'd0;
        ref_q2 = 32'd0;
      end else if (read_en) begin
        ref_q1 = ref_read(rs1_id);
        ref_q2 = ref_read(rs2_id);
      end
      if (busy) begin
        ref_mem[32 - sweep_left] = 32'd0;
        sweep_left--;
      end else if (reg_write_wb && rd_wb != 5'd0) begin
        ref_mem[rd_wb] = rd_data_wb;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rn);
    apply(rn, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    adv();
  endtask

  // Run up to 40 idle cycles and return how many showed init_busy high.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      apply(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
      if (a_busy === 1'b1) n++;
      adv();
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        ren;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int n;
    tbl[0]  = '{1'b1, 5'd10, 32'hDEADBEEF, 5'd0,  5'd0,  1'b1, 32'h0,        32'h0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        5'd10, 5'd10, 1'b1, 32'hDEADBEEF, 32'h0};
    tbl[2]  = '{1'b1, 5'd0,  32'h99990000, 5'd10, 5'd10, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b1, 32'h0,        32'hDEADBEEF};
    tbl[4]  = '{1'b1, 5'd7,  32'h11110000, 5'd0,  5'd0,  1'b1, 32'h0,        32'h0};
    tbl[5]  = '{1'b1, 5'd7,  32'h22220000, 5'd7,  5'd7,  1'b1, 32'h11110000, 32'h0};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  1'b1, 32'h22220000, 32'h11110000};
    tbl[7]  = '{1'b1, 5'd1,  32'hAAAAAAAA, 5'd7,  5'd7,  1'b1, 32'h22220000, 32'h22220000};
    tbl[8]  = '{1'b1, 5'd2,  32'hBBBBBBBB, 5'd1,  5'd1,  1'b1, 32'hAAAAAAAA, 32'h22220000};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd1,  1'b1, 32'hAAAAAAAA, 32'hAAAAAAAA};
    tbl[10] = '{1'b0, 5'd0,  32'h0,        5'd2,  5'd2,  1'b0, 32'hBBBBBBBB, 32'hAAAAAAAA};
    tbl[11] = '{1'b0, 5'd0,  32'h0,        5'd2,  5'd2,  1'b0, 32'hBBBBBBBB, 32'hAAAAAAAA};
    tbl[12] = '{1'b0, 5'd0,  32'h0,        5'd2,  5'd2,  1'b0, 32'hBBBBBBBB, 32'hAAAAAAAA};
    tbl[13] = '{1'b0, 5'd0,  32'h0,        5'd2,  5'd2,  1'b1, 32'hBBBBBBBB, 32'hAAAAAAAA};
    tbl[14] = '{1'b0, 5'd0,  32'h0,        5'd2,  5'd2,  1'b1, 32'hBBBBBBBB, 32'hBBBBBBBB};

    // First reset edge establishes a known DUT state before any comparison.
    rst_n = 1'b0; read_en = 1'b1; rs1_id = 5'd0; rs2_id = 5'd0;
    rd_wb = 5'd0; reg_write_wb = 1'b0; rd_data_wb = 32'd0;
    adv();

    // Reset held 3 cycles, then exactly 31 busy cycles.
    for (int i = 0; i < 3; i++) idle(1'b0);
    count_busy(n);
    chk("init_count", 32'(n), 32'd31);
    apply(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 1'b1);
    chk("x5_after_init", a_rs1, 32'd0);
    chk("x31_after_init", a_rs2, 32'd0);
    adv();

    // Directed vectors: write/read latency, x0, no bypass, stall hold.
    for (int i = 0; i < 15; i++) begin
      apply(1'b1, tbl[i].we, tbl[i].rd, tbl[i].wd, tbl[i].a1, tbl[i].a2, tbl[i].ren);
      chk($sformatf("vec%0d_a_rs1", i), a_rs1, tbl[i].exp_a);
      chk($sformatf("vec%0d_b_rs1", i), b_rs1, tbl[i].exp_b);
      chk($sformatf("vec%0d_a_rs2", i), a_rs2, tbl[i].exp_a);
      adv();
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 63) != 0), 1'($urandom), 5'($urandom),
            $urandom, 5'($urandom), 5'($urandom), ($urandom_range(0, 3) != 0));
      adv();
    end
    while (sweep_left > 0) idle(1'b1);

    // Make x3 nonzero, then restart the sweep with a dropped write and a
    // reset mid-sweep.
    apply(1'b1, 1'b1, 5'd3, 32'hCAFEF00D, 5'd0, 5'd0, 1'b1);
    adv();
    idle(1'b0);
    for (int k = 1; k <= 10; k++) begin
      apply((k != 10), (k == 5), 5'd3, 32'h12345678, 5'd3, 5'd3, 1'b1);
      adv();
    end
    count_busy(n);
    chk("init_count_restart", 32'(n), 32'd31);
    apply(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b1);
    chk("x3_after_restart_a", a_rs1, 32'd0);
    adv();
    apply(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b1);
    chk("x3_after_restart_b", b_rs1, 32'd0);
    adv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
